rc4_phase_sequencer: RTL and testbench

//  Top-level scheduler for the RC4 core. Runs the three S-memory phases in order
//  (init S[i]=i, key-schedule shuffle, PRGA decrypt) via start/fin_strobe handshakes.

---
 rtl/rc4_phase_sequencer_if.sv | 52 +++++
 rtl/rc4_phase_sequencer.sv | 121 ++++++++++++
 tb/tb_rc4_phase_sequencer.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/rc4_phase_sequencer_if.sv
// Bundle of RC4 phase-sequencer signals: run request/status, the three
// sub-FSM start/fin_strobe handshakes with their S-port requests, and the S RAM port.
interface rc4_phase_sequencer_if;
  logic       start;
  logic       busy;
  logic       done;
  logic       err;
  logic [1:0] phase;

  logic       init_start;
  logic       init_done;
  logic [7:0] init_addr;
  logic [7:0] init_data;
  logic       init_wr_en;

  logic       shuf_start;
  logic       shuf_done;
  logic [7:0] shuf_addr;
  logic [7:0] shuf_data;
  logic       shuf_wr_en;

  logic       prga_start;
  logic       prga_done;
  logic [7:0] prga_addr;
  logic [7:0] prga_data;
  logic       prga_wr_en;

  logic [7:0] s_addr;
  logic [7:0] s_data;
  logic       s_wr_en;

  // The sequencer is the master: it issues start pulses and owns the S RAM port.
  modport master (
    input  start,
    input  init_done, init_addr, init_data, init_wr_en,
    input  shuf_done, shuf_addr, shuf_data, shuf_wr_en,
    input  prga_done, prga_addr, prga_data, prga_wr_en,
    output init_start, shuf_start, prga_start,
    output s_addr, s_data, s_wr_en,
    output phase, busy, done, err
  );

  modport slave (
    output start,
    output init_done, init_addr, init_data, init_wr_en,
    output shuf_done, shuf_addr, shuf_data, shuf_wr_en,
    output prga_done, prga_addr, prga_data, prga_wr_en,
    input  init_start, shuf_start, prga_start,
    input  s_addr, s_data, s_wr_en,
    input  phase, busy, done, err
  );
endinterface

// File: rtl/rc4_phase_sequencer.sv
// RC4 top-level scheduler: runs init, key-schedule shuffle and PRGA phases in order,
// muxes the owning phase onto the single-port S RAM, and times out a stalled phase.
module rc4_phase_sequencer #(
  parameter int TIMEOUT = 4096,
  parameter int CNT_W   = 13
) (
  input  logic                      clk,
  input  logic                      rst,
  rc4_phase_sequencer_if.master     bus
);

  typedef enum logic [3:0] {
    IDLE       = 4'd0,
    START_INIT = 4'd1,
    WAIT_INIT  = 4'd2,
    START_SHUF = 4'd3,
    WAIT_SHUF  = 4'd4,
    START_PRGA = 4'd5,
    WAIT_PRGA  = 4'd6,
    DONE_S     = 4'd7,
    ERR        = 4'd8
  } state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] cnt;
  logic             expired;

  assign expired = (cnt == LAST);

  function automatic logic [1:0] phase_of(input state_t s);
    case (s)
      START_INIT, WAIT_INIT: phase_of = 2'd1;
      START_SHUF, WAIT_SHUF: phase_of = 2'd2;
      START_PRGA, WAIT_PRGA: phase_of = 2'd3;
      default:               phase_of = 2'd0;
    endcase
  endfunction

  // A completion strobe beats watchdog expiry when both land on the same cycle.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:       if (bus.start) state_next = START_INIT;
      START_INIT: state_next = WAIT_INIT;
      WAIT_INIT: begin
        if (bus.init_done)  state_next = START_SHUF;
        else if (expired)   state_next = ERR;
      end
      START_SHUF: state_next = WAIT_SHUF;
      WAIT_SHUF: begin
        if (bus.shuf_done)  state_next = START_PRGA;
        else if (expired)   state_next = ERR;
      end
      START_PRGA: state_next = WAIT_PRGA;
      WAIT_PRGA: begin
        if (bus.prga_done)  state_next = DONE_S;
        else if (expired)   state_next = ERR;
      end
      DONE_S:     state_next = bus.start ? START_INIT : IDLE;
      ERR:        if (bus.start) state_next = START_INIT;
      default:    state_next = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      cnt            <= '0;
      bus.init_start <= 1'b0;
      bus.shuf_start <= 1'b0;
      bus.prga_start <= 1'b0;
      bus.phase      <= 2'd0;
      bus.busy       <= 1'b0;
      bus.done       <= 1'b0;
      bus.err        <= 1'b0;
    end else begin
      state <= state_next;
      case (state)
        WAIT_INIT, WAIT_SHUF, WAIT_PRGA: cnt <= cnt + 1'b1;
        default:                         cnt <= '0;
      endcase
      bus.init_start <= (state_next == START_INIT);
      bus.shuf_start <= (state_next == START_SHUF);
      bus.prga_start <= (state_next == START_PRGA);
      bus.phase      <= phase_of(state_next);
      bus.busy       <= !((state_next == IDLE) || (state_next == DONE_S) ||
                          (state_next == ERR));
      bus.done       <= (state_next == DONE_S);
      bus.err        <= (state_next == ERR);
    end
  end

  always_comb begin
    bus.s_addr  = 8'd0;
    bus.s_data  = 8'd0;
    bus.s_wr_en = 1'b0;
    case (bus.phase)
      2'd1: begin
        bus.s_addr  = bus.init_addr;
        bus.s_data  = bus.init_data;
        bus.s_wr_en = bus.init_wr_en;
      end
      2'd2: begin
        bus.s_addr  = bus.shuf_addr;
        bus.s_data  = bus.shuf_data;
        bus.s_wr_en = bus.shuf_wr_en;
      end
      2'd3: begin
        bus.s_addr  = bus.prga_addr;
        bus.s_data  = bus.prga_data;
        bus.s_wr_en = bus.prga_wr_en;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_rc4_phase_sequencer.sv
// Self-checking bench for rc4_phase_sequencer: a default-timeout instance and a
// TIMEOUT=8 instance share stimulus; pulses are scored against an expected-event queue.
module tb_rc4_phase_sequencer;

  logic clk;
  logic rst;
  logic sel;
  logic start, init_done, shuf_done, prga_done;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  typedef struct {
    int code;
    int cycle;
  } ev_t;
  ev_t sbq[$];

  rc4_phase_sequencer_if bus_def ();
  rc4_phase_sequencer_if bus_wd ();

  rc4_phase_sequencer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_def)
  );

  rc4_phase_sequencer #(.TIMEOUT(8), .CNT_W(4)) dut_wd (
    .clk (clk),
    .rst (rst),
    .bus (bus_wd)
  );

  assign bus_def.start      = start;
  assign bus_def.init_done  = init_done;
  assign bus_def.init_addr  = 8'h11;
  assign bus_def.init_data  = 8'hA1;
  assign bus_def.init_wr_en = 1'b1;
  assign bus_def.shuf_done  = shuf_done;
  assign bus_def.shuf_addr  = 8'h22;
  assign bus_def.shuf_data  = 8'hB2;
  assign bus_def.shuf_wr_en = 1'b1;
  assign bus_def.prga_done  = prga_done;
  assign bus_def.prga_addr  = 8'h33;
  assign bus_def.prga_data  = 8'hC3;
  assign bus_def.prga_wr_en = 1'b1;

  assign bus_wd.start      = start;
  assign bus_wd.init_done  = init_done;
  assign bus_wd.init_addr  = 8'h11;
  assign bus_wd.init_data  = 8'hA1;
  assign bus_wd.init_wr_en = 1'b1;
  assign bus_wd.shuf_done  = shuf_done;
  assign bus_wd.shuf_addr  = 8'h22;
  assign bus_wd.shuf_data  = 8'hB2;
  assign bus_wd.shuf_wr_en = 1'b1;
  assign bus_wd.prga_done  = prga_done;
  assign bus_wd.prga_addr  = 8'h33;
  assign bus_wd.prga_data  = 8'hC3;
  assign bus_wd.prga_wr_en = 1'b1;

  logic       o_init_start, o_shuf_start, o_prga_start;
  logic       o_busy, o_done, o_err, o_wr_en;
  logic [1:0] o_phase;
  logic [7:0] o_addr, o_data;

  assign o_init_start = sel ? bus_wd.init_start : bus_def.init_start;
  assign o_shuf_start = sel ? bus_wd.shuf_start : bus_def.shuf_start;
  assign o_prga_start = sel ? bus_wd.prga_start : bus_def.prga_start;
  assign o_busy       = sel ? bus_wd.busy       : bus_def.busy;
  assign o_done       = sel ? bus_wd.done       : bus_def.done;
  assign o_err        = sel ? bus_wd.err        : bus_def.err;
  assign o_phase      = sel ? bus_wd.phase      : bus_def.phase;
  assign o_addr       = sel ? bus_wd.s_addr     : bus_def.s_addr;
  assign o_data       = sel ? bus_wd.s_data     : bus_def.s_data;
  assign o_wr_en      = sel ? bus_wd.s_wr_en    : bus_def.s_wr_en;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // One clock cycle with the given strobes held for exactly that cycle.
  task automatic applyStimulus(input logic s, input logic id, input logic sd, input logic pd);
    start     = s;
    init_done = id;
    shuf_done = sd;
    prga_done = pd;
    @(posedge clk);
    #1;
    start     = 1'b0;
    init_done = 1'b0;
    shuf_done = 1'b0;
    prga_done = 1'b0;
  endtask

  // Codes: 1 init_start, 2 shuf_start, 3 prga_start, 4 done; due in the cycle after the next edge.
  task automatic expectPulse(input int code);
    sbq.push_back('{code, cyc + 1});
  endtask

  task automatic scorePulse(input int code);
    ev_t e;
    if (sbq.size() == 0) begin
      checkOutput("sb_unexpected_pulse", code, 0);
    end else begin
      e = sbq.pop_front();
      checkOutput("sb_pulse_code", code, e.code);
      checkOutput("sb_pulse_cycle", cyc, e.cycle);
    end
  endtask

  always @(negedge clk) begin
    if (o_init_start === 1'b1) scorePulse(1);
    if (o_shuf_start === 1'b1) scorePulse(2);
    if (o_prga_start === 1'b1) scorePulse(3);
    if (o_done === 1'b1)       scorePulse(4);
  end

  task automatic waitCycles(input int n, input logic [1:0] ph, input logic [7:0] addr,
                            input logic bsy);
    repeat (n) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput("run_phase", o_phase, ph);
      checkOutput("run_s_addr", o_addr, addr);
      checkOutput("run_busy", o_busy, bsy);
    end
  endtask

  task automatic resetBoth(input logic new_sel);
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    sel = new_sel;
    rst = 1'b0;
  endtask

  task automatic checkIdleLike(input string tag, input logic exp_err, input logic exp_done);
    checkOutput({tag, "_phase"}, o_phase, 0);
    checkOutput({tag, "_busy"}, o_busy, 0);
    checkOutput({tag, "_err"}, o_err, exp_err);
    checkOutput({tag, "_done"}, o_done, exp_done);
    checkOutput({tag, "_s_addr"}, o_addr, 0);
    checkOutput({tag, "_s_data"}, o_data, 0);
    checkOutput({tag, "_s_wr_en"}, o_wr_en, 0);
  endtask

  initial begin
    rst = 1'b1;
    sel = 1'b0;
    start = 1'b0;
    init_done = 1'b0;
    shuf_done = 1'b0;
    prga_done = 1'b0;
    @(posedge clk);
    #1;

    // Full run on the default-timeout instance with realistic phase lengths.
    resetBoth(1'b0);
    checkIdleLike("reset", 1'b0, 1'b0);
    checkOutput("reset_init_start", o_init_start, 0);
    expectPulse(1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("start_init_phase", o_phase, 1);
    checkOutput("start_init_s_data", o_data, 8'hA1);
    checkOutput("start_init_wr_en", o_wr_en, 1);
    waitCycles(256, 2'd1, 8'h11, 1'b1);
    expectPulse(2);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("start_shuf_s_data", o_data, 8'hB2);
    waitCycles(1536, 2'd2, 8'h22, 1'b1);
    expectPulse(3);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("start_prga_s_data", o_data, 8'hC3);
    waitCycles(200, 2'd3, 8'h33, 1'b1);
    expectPulse(4);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    checkIdleLike("done_s", 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkIdleLike("back_idle", 1'b0, 1'b0);

    // Watchdog expiry in WAIT_SHUF on the TIMEOUT=8 instance, then restart from ERR.
    resetBoth(1'b1);
    expectPulse(1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    waitCycles(3, 2'd1, 8'h11, 1'b1);
    expectPulse(2);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    waitCycles(1, 2'd2, 8'h22, 1'b1);
    waitCycles(7, 2'd2, 8'h22, 1'b1);
    checkOutput("wd_pre_expiry_err", o_err, 0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkIdleLike("wd_err", 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("wd_err_sticky", o_err, 1);
    expectPulse(1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("err_restart_err", o_err, 0);
    checkOutput("err_restart_phase", o_phase, 1);

    // Strobe on the expiry cycle wins; a stray init_done in WAIT_SHUF is ignored.
    waitCycles(2, 2'd1, 8'h11, 1'b1);
    expectPulse(2);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("stray_init_done_phase", o_phase, 2);
    waitCycles(6, 2'd2, 8'h22, 1'b1);
    expectPulse(3);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("expiry_tie_err", o_err, 0);
    checkOutput("expiry_tie_phase", o_phase, 3);

    // A start request while busy in WAIT_PRGA is dropped.
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("busy_start_phase", o_phase, 3);
    checkOutput("busy_start_busy", o_busy, 1);
    expectPulse(4);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("wd_run_done", o_done, 1);
    checkOutput("wd_run_err", o_err, 0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkIdleLike("wd_run_idle", 1'b0, 1'b0);

    // Reset mid-run in WAIT_SHUF, then a normal short run.
    resetBoth(1'b0);
    expectPulse(1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    waitCycles(2, 2'd1, 8'h11, 1'b1);
    expectPulse(2);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    waitCycles(3, 2'd2, 8'h22, 1'b1);
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    checkIdleLike("mid_rst", 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkIdleLike("post_rst", 1'b0, 1'b0);
    expectPulse(1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    waitCycles(3, 2'd1, 8'h11, 1'b1);
    expectPulse(2);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    waitCycles(3, 2'd2, 8'h22, 1'b1);
    expectPulse(3);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    waitCycles(3, 2'd3, 8'h33, 1'b1);
    expectPulse(4);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    checkIdleLike("rerun_done", 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("sb_all_pulses_seen", sbq.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
